// File: rtl/frame_pkg.sv
// Shared types and defaults for the framebuffer scan-out reader.
package frame_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;
  localparam int DEF_PIX_W  = 3;

  // One output FIFO entry: pixel value plus its raster position flags.
  typedef struct packed {
    logic [DEF_PIX_W-1:0] data;
    logic                 eol;
    logic                 last;
  } pix_entry_t;

endpackage

// File: rtl/frame_reader_pix_fifo.sv
// Small synchronous FIFO with combinational head, used as the reader's output buffer.
module pix_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push, do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/frame_reader.sv
// Raster-order framebuffer scan-out: issues RAM reads under a credit limit and
// streams the returned pixels out with end-of-line / end-of-frame flags.
module frame_reader
  import frame_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int PIX_W      = DEF_PIX_W,
  parameter int RD_LATENCY = 2,
  parameter int DEPTH      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             rd_en,
  output logic [9:0]       rd_x,
  output logic [8:0]       rd_y,
  input  logic [PIX_W-1:0] rd_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_eol,
  output logic             pix_last,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(RD_LATENCY + 1);

  state_t          state_reg, state_next;
  logic [9:0]      x_reg;
  logic [8:0]      y_reg;
  logic [OW-1:0]   outstanding_reg;
  logic [2:0]      sb_reg [RD_LATENCY];  // {valid, eol, last} per read in flight
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  pix_entry_t      push_entry, head_entry;
  logic            at_eol, at_last, tap_valid, push, pop;

  assign at_eol    = (x_reg == 10'(WIDTH - 1));
  assign at_last   = at_eol && (y_reg == 9'(HEIGHT - 1));
  assign tap_valid = sb_reg[RD_LATENCY-1][2];
  assign push      = tap_valid && !fifo_full;
  assign pix_valid = !fifo_empty;
  assign pop       = pix_valid && pix_ready;

  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    case (state_reg)
      IDLE:  if (start) state_next = SCAN;
      SCAN: begin
        rd_en = (int'(fifo_count) + int'(outstanding_reg)) < DEPTH;
        if (rd_en && at_last) state_next = DRAIN;
      end
      // Finish on the cycle the last buffered pixel is handed over.
      DRAIN: if (outstanding_reg == '0 &&
                 (fifo_empty || (fifo_count == CW'(1) && pop))) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      x_reg           <= '0;
      y_reg           <= '0;
      outstanding_reg <= '0;
    end else begin
      state_reg       <= state_next;
      outstanding_reg <= outstanding_reg + OW'(rd_en) - OW'(tap_valid);
      if (state_reg == IDLE && start) begin
        x_reg <= '0;
        y_reg <= '0;
      end else if (rd_en) begin
        if (at_eol) begin
          x_reg <= '0;
          y_reg <= at_last ? '0 : y_reg + 9'd1;
        end else begin
          x_reg <= x_reg + 10'd1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_sb
    always_ff @(posedge clk) begin
      if (reset) begin
        sb_reg[gi] <= '0;
      end else if (gi == 0) begin
        sb_reg[gi] <= {rd_en, rd_en && at_eol, rd_en && at_last};
      end else begin
        sb_reg[gi] <= sb_reg[(gi > 0) ? gi - 1 : 0];
      end
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.data = DEF_PIX_W'(rd_data);
    push_entry.eol  = sb_reg[RD_LATENCY-1][1];
    push_entry.last = sb_reg[RD_LATENCY-1][0];
  end

  pix_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(pix_entry_t)),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (push_entry),
    .pop     (pop),
    .rd_data (head_entry),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign pix_data = fifo_empty ? '0 : PIX_W'(head_entry.data);
  assign pix_eol  = !fifo_empty && head_entry.eol;
  assign pix_last = !fifo_empty && head_entry.last;
  assign rd_x     = x_reg;
  assign rd_y     = y_reg;
  assign busy     = (state_reg == SCAN) || (state_reg == DRAIN);
  assign done     = (state_reg == DONE);

endmodule
